// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: captures 2048 ADC samples into fft_top banks, starts the FFT,
// waits for completion and streams the result banks out in natural order.
module fft_seq_ctrl #(
    parameter int BANKS   = 4,
    parameter int DEPTH   = 512,
    parameter int DW      = 16,
    parameter int RD_LAT  = 2,
    parameter int TIMEOUT = 65535
) (
    input  logic                 iCLK,
    input  logic                 iRESET,
    input  logic                 iARM,
    input  logic                 iSMP_VALID,
    input  logic signed [DW-1:0] iSMP_DATA,
    output logic                 oSMP_READY,
    output logic [DW-1:0]        oDATA,
    output logic [8:0]           oADDR_WR,
    output logic [BANKS-1:0]     oWE,
    output logic                 oSTART,
    input  logic                 iFFT_RDY,
    output logic [8:0]           oADDR_RD,
    input  logic [DW-1:0]        iRD_DATA_0,
    input  logic [DW-1:0]        iRD_DATA_1,
    input  logic [DW-1:0]        iRD_DATA_2,
    input  logic [DW-1:0]        iRD_DATA_3,
    output logic                 oOUT_VALID,
    output logic [DW-1:0]        oOUT_DATA,
    output logic                 oOUT_LAST,
    output logic                 oBUSY,
    output logic                 oERR
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(BANKS);
    localparam int IW = AW + BW;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST = IW'(BANKS * DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, START, WAIT_FFT, DUMP, FLUSH
    } state_t;

    state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic err_q, err_d;
    logic ready_q, start_q, busy_q, rdy_q;
    logic accept, issue;

    // Read-side pipeline: valid, last and bank select track the RAM latency
    logic [RD_LAT-1:0]         pv_q;
    logic [RD_LAT-1:0]         pl_q;
    logic [RD_LAT-1:0][BW-1:0] pb_q;
    logic [DW-1:0]             rd_mux;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        accept  = 1'b0;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (iARM) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                accept = iSMP_VALID & ready_q;
                if (accept) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST) state_d = START;
                end
            end
            START: begin
                state_d = WAIT_FFT;
                cnt_d   = '0;
            end
            WAIT_FFT: begin
                // Only a fresh rising edge counts; a stale high level does not
                if (iFFT_RDY & ~rdy_q) begin
                    state_d = DUMP;
                    rd_d    = '0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DUMP: begin
                issue = 1'b1;
                rd_d  = rd_q + 1'b1;
                if (rd_q == LAST) state_d = FLUSH;
            end
            FLUSH: begin
                if (pv_q[RD_LAT-1] & pl_q[RD_LAT-1]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            pv_q    <= '0;
            pl_q    <= '0;
            pb_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ready_q <= (state_d == LOAD);
            start_q <= (state_q == START);
            busy_q  <= (state_d != IDLE);
            rdy_q   <= iFFT_RDY;
            pv_q[0] <= issue;
            pl_q[0] <= issue & (rd_q == LAST);
            pb_q[0] <= rd_q[IW-1:AW];
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pl_q[i] <= pl_q[i-1];
                pb_q[i] <= pb_q[i-1];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (pb_q[RD_LAT-1])
            2'd0: rd_mux = iRD_DATA_0;
            2'd1: rd_mux = iRD_DATA_1;
            2'd2: rd_mux = iRD_DATA_2;
            2'd3: rd_mux = iRD_DATA_3;
        endcase
    end

    always_comb begin
        oWE = '0;
        if (accept) oWE[idx_q[IW-1:AW]] = 1'b1;
    end

    assign oSMP_READY = ready_q;
    assign oDATA      = accept ? iSMP_DATA : '0;
    assign oADDR_WR   = accept ? idx_q[AW-1:0] : '0;
    assign oSTART     = start_q;
    assign oADDR_RD   = issue ? rd_q[AW-1:0] : '0;
    assign oOUT_VALID = pv_q[RD_LAT-1];
    assign oOUT_DATA  = pv_q[RD_LAT-1] ? rd_mux : '0;
    assign oOUT_LAST  = pv_q[RD_LAT-1] & pl_q[RD_LAT-1];
    assign oBUSY      = busy_q;
    assign oERR       = err_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb_fft_seq_ctrl: randomized scoreboard bench for fft_seq_ctrl with a
// latency-modelled result RAM returning bank*1000+addr.
module tb_fft_seq_ctrl;

    localparam int LAT = 3;
    localparam int TMO = 200;
    localparam int N   = 2048;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic arm = 1'b0;
    logic smp_valid = 1'b0;
    logic fft_rdy = 1'b0;
    logic [15:0] smp_data = '0;
    logic smp_ready, start, out_valid, out_last, busy, err;
    logic [15:0] wdata, out_data;
    logic [8:0] waddr, raddr;
    logic [3:0] we;
    logic [8:0] ahist [LAT];
    logic [15:0] rd [4];

    fft_seq_ctrl #(.RD_LAT(LAT), .TIMEOUT(TMO)) dut (
        .iCLK(clk), .iRESET(rst_n), .iARM(arm),
        .iSMP_VALID(smp_valid), .iSMP_DATA(smp_data),
        .oSMP_READY(smp_ready), .oDATA(wdata), .oADDR_WR(waddr),
        .oWE(we), .oSTART(start), .iFFT_RDY(fft_rdy),
        .oADDR_RD(raddr),
        .iRD_DATA_0(rd[0]), .iRD_DATA_1(rd[1]),
        .iRD_DATA_2(rd[2]), .iRD_DATA_3(rd[3]),
        .oOUT_VALID(out_valid), .oOUT_DATA(out_data),
        .oOUT_LAST(out_last), .oBUSY(busy), .oERR(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Result RAM model: data for an address appears LAT cycles later
    always @(posedge clk) begin
        ahist[0] <= raddr;
        for (int i = 1; i < LAT; i++) ahist[i] <= ahist[i-1];
    end
    always_comb begin
        for (int b = 0; b < 4; b++)
            rd[b] = 16'(b * 1000) + {7'd0, ahist[LAT-1]};
    end

    logic [15:0] smp_mem [N];
    logic [28:0] exp_wr [$];
    logic [16:0] exp_out [$];
    int pass_cnt = 0;
    int chk_cnt = 0;
    int wr_cnt, val_cnt, start_cnt, start_cyc, first_val, last_val, last_acc;

    task automatic chk(input string name, input longint got, input longint exp);
        chk_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (we != 4'd0) begin
                wr_cnt++;
                chk("write_on_valid", smp_valid, 1);
                if (exp_wr.size() == 0) chk("extra_write", we, 0);
                else chk("write_word", {we, waddr, wdata}, exp_wr.pop_front());
            end
            if (out_valid) begin
                if (val_cnt == 0) first_val = cyc;
                last_val = cyc;
                val_cnt++;
                if (exp_out.size() == 0) chk("extra_output", out_valid, 0);
                else chk("out_word", {out_last, out_data}, exp_out.pop_front());
            end
            if (start) begin
                start_cnt++;
                start_cyc = cyc;
            end
        end
    end

    task automatic prep(input bit rnd);
        exp_wr.delete();
        exp_out.delete();
        for (int k = 0; k < N; k++) begin
            smp_mem[k] = rnd ? 16'($urandom) : 16'(k);
            exp_wr.push_back({4'(1 << (k / 512)), 9'(k % 512), smp_mem[k]});
            exp_out.push_back({k == N - 1, 16'((k / 512) * 1000 + k % 512)});
        end
        wr_cnt = 0;
        val_cnt = 0;
        start_cnt = 0;
        start_cyc = 0;
        first_val = 0;
        last_val = 0;
    endtask

    task automatic do_arm();
        @(posedge clk); #1; arm = 1'b1;
        @(posedge clk); #1; arm = 1'b0;
    endtask

    task automatic load(input bit rnd, input bit pulses, input int n);
        int k = 0;
        int g = 0;
        while (k < n && g < 20000) begin
            @(posedge clk); #1;
            smp_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            smp_data = smp_mem[k];
            arm = pulses && ($urandom_range(0, 63) == 0);
            @(negedge clk);
            if (smp_valid && smp_ready) begin
                k++;
                last_acc = cyc;
            end
            g++;
        end
        chk("load_accepts", k, n);
        @(posedge clk); #1;
        smp_valid = 1'b0;
        arm = 1'b0;
    endtask

    task automatic wait_start();
        int g = 0;
        while (start_cnt == 0 && g < 100) begin
            @(negedge clk); #1;
            g++;
        end
        chk("start_seen", start_cnt, 1);
        chk("start_delay", start_cyc - last_acc, 2);
    endtask

    task automatic chk_zero(input string name);
        chk(name, {smp_ready, start, out_valid, out_last, busy, err,
                   we, waddr, raddr, wdata, out_data}, 0);
    endtask

    task automatic run_full(input bit rnd, input bit rdy_pre, input int gap);
        int rise;
        int g = 0;
        prep(rnd);
        fft_rdy = rdy_pre;
        do_arm();
        load(rnd, !rnd, N);
        wait_start();
        repeat (10) @(posedge clk);
        #1 fft_rdy = 1'b0;
        @(posedge clk); #1; arm = 1'b1;
        @(posedge clk); #1; arm = 1'b0;
        repeat (gap - 2) @(posedge clk);
        #1 fft_rdy = 1'b1;
        rise = cyc;
        repeat (5) @(posedge clk);
        #1 arm = 1'b1;
        @(posedge clk); #1; arm = 1'b0;
        while (val_cnt < N && g < 3000) begin
            @(negedge clk); #1;
            g++;
        end
        chk("out_count", val_cnt, N);
        chk("first_out_latency", first_val - rise, 1 + LAT);
        chk("out_contiguous", last_val - first_val, N - 1);
        chk("write_count", wr_cnt, N);
        chk("start_pulses", start_cnt, 1);
        repeat (LAT + 2) @(negedge clk);
        #1;
        chk("idle_after_dump", busy, 0);
        chk("no_err", err, 0);
        chk("queues_drained", exp_wr.size() + exp_out.size(), 0);
    endtask

    initial begin
        int g;
        int e;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset_outputs");
        @(negedge clk) rst_n = 1'b1;

        prep(1'b0);
        do_arm();
        load(1'b0, 1'b0, 700);
        chk("busy_mid_load", busy, 1);
        rst_n = 1'b0;
        #1 chk_zero("reset_mid_load");
        exp_wr.delete();
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk("idle_after_release", busy, 0);

        run_full(1'b0, 1'b1, 100);
        run_full(1'b1, 1'b0, int'($urandom_range(20, 150)));

        prep(1'b1);
        fft_rdy = 1'b0;
        do_arm();
        load(1'b1, 1'b0, N);
        wait_start();
        g = 0;
        while (!err && g < 400) begin
            @(negedge clk); #1;
            g++;
        end
        e = cyc;
        chk("err_timing", e - start_cyc, TMO);
        chk("idle_on_timeout", busy, 0);
        chk("no_dump_on_timeout", val_cnt, 0);
        do_arm();
        chk("err_cleared_by_arm", err, 0);
        chk("busy_after_arm", busy, 1);
        rst_n = 1'b0;
        #1 chk_zero("final_reset");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
